// File: rtl/psramc_hrr_seq.sv
// HyperRAM register-space sequencer: RESET# pulse generation, ID/CR auto-read
// into a 64-bit shadow, and CR0/CR1 writes over a single-outstanding command port.
module psramc_hrr_seq #(
    parameter logic [31:0] A_ID0 = 32'h0000_0000,
    parameter logic [31:0] A_ID1 = 32'h0000_0001,
    parameter logic [31:0] A_CR0 = 32'h0000_0800,
    parameter logic [31:0] A_CR1 = 32'h0000_0801
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        hrr_reset,
    input  logic        hrr_read,
    input  logic        hrr_write,
    input  logic        hrr_wsel,
    input  logic [15:0] hrr_wdata,
    input  logic [7:0]  tSYS,
    input  logic [3:0]  tRP,
    input  logic [3:0]  tRH,
    output logic        hrr_rdone,
    output logic [63:0] hrr_rdata,
    output logic        psram_rst_n,
    output logic        cmd_valid,
    input  logic        cmd_ready,
    output logic        cmd_write,
    output logic [31:0] cmd_addr,
    output logic [15:0] cmd_wdata,
    input  logic        rsp_valid,
    input  logic [15:0] rsp_rdata,
    input  logic        rsp_error,
    output logic        ready,
    output logic        error
);

    typedef enum logic [2:0] {
        S_IDLE, S_RST_LO, S_RST_HI, S_RD_CMD, S_RD_WAIT, S_WR_CMD, S_WR_WAIT
    } state_e;

    state_e      state_q, state_d;
    logic [1:0]  rd_idx_q, rd_idx_d;
    logic [9:0]  acc_q, acc_d;
    logic [3:0]  us_q, us_d;
    logic        pend_rd_q, pend_rd_d;
    logic        pend_wr_q, pend_wr_d;
    logic        pend_sel_q, pend_sel_d;
    logic [15:0] pend_data_q, pend_data_d;
    logic        wr_sel_q, wr_sel_d;
    logic [15:0] wr_data_q, wr_data_d;
    logic [63:0] stage_q, stage_d;
    logic [63:0] rdata_q, rdata_d;
    logic        rdone_q, rdone_d;
    logic        ready_q, ready_d;
    logic        error_q, error_d;

    logic [7:0]  tsys_eff;
    logic [3:0]  trp_eff, trh_eff, us_next;
    logic [10:0] acc_sum, acc_wrap;
    logic        us_tick, in_rst, in_wait, rsp_ok, rsp_bad;
    logic        start_rd, start_wr, rd_last_ok;

    // Zero timing fields behave as 1 so the timer always terminates.
    assign tsys_eff = (tSYS == 8'd0) ? 8'd1 : tSYS;
    assign trp_eff  = (tRP == 4'd0) ? 4'd1 : tRP;
    assign trh_eff  = (tRH == 4'd0) ? 4'd1 : tRH;
    assign acc_sum  = {1'b0, acc_q} + {3'b000, tsys_eff};
    assign acc_wrap = acc_sum - 11'd1000;
    assign us_tick  = (acc_sum >= 11'd1000);
    assign us_next  = us_q + 4'd1;

    assign in_rst   = (state_q == S_RST_LO) || (state_q == S_RST_HI);
    assign in_wait  = (state_q == S_RD_WAIT) || (state_q == S_WR_WAIT);
    // Responses only count in WAIT states, and never in the cycle a reset aborts.
    assign rsp_ok   = in_wait && rsp_valid && !rsp_error && !hrr_reset;
    assign rsp_bad  = in_wait && rsp_valid && rsp_error && !hrr_reset;
    assign start_rd = (state_q == S_IDLE) && !hrr_reset && (hrr_read || pend_rd_q);
    assign start_wr = (state_q == S_IDLE) && !hrr_reset && !start_rd && (hrr_write || pend_wr_q);
    assign rd_last_ok = (state_q == S_RD_WAIT) && rsp_ok && (rd_idx_q == 2'd3);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (hrr_reset) begin
            state_d = S_RST_LO;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start_rd)      state_d = S_RD_CMD;
                    else if (start_wr) state_d = S_WR_CMD;
                end
                S_RST_LO:  if (us_tick && us_next == trp_eff) state_d = S_RST_HI;
                S_RST_HI:  if (us_tick && us_next == trh_eff) state_d = S_RD_CMD;
                S_RD_CMD:  if (cmd_ready) state_d = S_RD_WAIT;
                S_RD_WAIT: begin
                    if (rsp_valid) begin
                        if (rsp_error || rd_idx_q == 2'd3) state_d = S_IDLE;
                        else                               state_d = S_RD_CMD;
                    end
                end
                S_WR_CMD:  if (cmd_ready) state_d = S_WR_WAIT;
                S_WR_WAIT: if (rsp_valid) state_d = S_IDLE;
                default:   state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        psram_rst_n = (state_q != S_RST_LO);
        cmd_valid   = (state_q == S_RD_CMD) || (state_q == S_WR_CMD);
        cmd_write   = (state_q == S_WR_CMD);
        cmd_wdata   = wr_data_q;
        ready       = ready_q && (state_q == S_IDLE);
        if (state_q == S_WR_CMD) begin
            cmd_addr = wr_sel_q ? A_CR1 : A_CR0;
        end else begin
            case (rd_idx_q)
                2'd0:    cmd_addr = A_ID0;
                2'd1:    cmd_addr = A_ID1;
                2'd2:    cmd_addr = A_CR0;
                default: cmd_addr = A_CR1;
            endcase
        end
    end

    always_comb begin
        acc_d       = acc_q;
        us_d        = us_q;
        rd_idx_d    = rd_idx_q;
        pend_rd_d   = pend_rd_q;
        pend_wr_d   = pend_wr_q;
        pend_sel_d  = pend_sel_q;
        pend_data_d = pend_data_q;
        wr_sel_d    = wr_sel_q;
        wr_data_d   = wr_data_q;
        stage_d     = stage_q;
        rdata_d     = rdata_q;
        rdone_d     = rd_last_ok;
        ready_d     = ready_q;
        error_d     = error_q;

        // Timer restarts on every state entry, including a reset re-entering RST_LO.
        if (hrr_reset || state_d != state_q || !in_rst) begin
            acc_d = 10'd0;
            us_d  = 4'd0;
        end else if (us_tick) begin
            acc_d = acc_wrap[9:0];
            us_d  = us_next;
        end else begin
            acc_d = acc_sum[9:0];
        end

        if (state_q == S_RD_WAIT && rsp_ok)
            rd_idx_d = rd_idx_q + 2'd1;
        else if (state_q != S_RD_CMD && state_q != S_RD_WAIT)
            rd_idx_d = 2'd0;

        if (hrr_write) begin
            pend_sel_d  = hrr_wsel;
            pend_data_d = hrr_wdata;
        end
        if (start_wr) begin
            wr_sel_d  = hrr_write ? hrr_wsel  : pend_sel_q;
            wr_data_d = hrr_write ? hrr_wdata : pend_data_q;
        end

        if (hrr_reset) begin
            pend_rd_d = 1'b0;
            pend_wr_d = 1'b0;
        end else begin
            if (start_rd || rd_last_ok) pend_rd_d = 1'b0;
            if (hrr_read && !start_rd)  pend_rd_d = 1'b1;
            if (start_wr)               pend_wr_d = 1'b0;
            else if (hrr_write)         pend_wr_d = 1'b1;
        end

        if (state_q == S_RD_WAIT && rsp_ok)
            stage_d[{rd_idx_q, 4'b0000} +: 16] = rsp_rdata;
        if (rd_last_ok)
            rdata_d = {rsp_rdata, stage_q[47:0]};
        if (state_q == S_WR_WAIT && rsp_ok) begin
            if (wr_sel_q) rdata_d[63:48] = wr_data_q;
            else          rdata_d[47:32] = wr_data_q;
        end

        if (hrr_reset || rsp_bad) ready_d = 1'b0;
        else if (rd_last_ok)      ready_d = 1'b1;
        if (hrr_reset)            error_d = 1'b0;
        else if (rsp_bad)         error_d = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q       <= '0;
            us_q        <= '0;
            rd_idx_q    <= '0;
            pend_rd_q   <= 1'b0;
            pend_wr_q   <= 1'b0;
            pend_sel_q  <= 1'b0;
            pend_data_q <= '0;
            wr_sel_q    <= 1'b0;
            wr_data_q   <= '0;
            stage_q     <= '0;
            rdata_q     <= '0;
            rdone_q     <= 1'b0;
            ready_q     <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            acc_q       <= acc_d;
            us_q        <= us_d;
            rd_idx_q    <= rd_idx_d;
            pend_rd_q   <= pend_rd_d;
            pend_wr_q   <= pend_wr_d;
            pend_sel_q  <= pend_sel_d;
            pend_data_q <= pend_data_d;
            wr_sel_q    <= wr_sel_d;
            wr_data_q   <= wr_data_d;
            stage_q     <= stage_d;
            rdata_q     <= rdata_d;
            rdone_q     <= rdone_d;
            ready_q     <= ready_d;
            error_q     <= error_d;
        end
    end

    assign hrr_rdone = rdone_q;
    assign hrr_rdata = rdata_q;
    assign error     = error_q;

endmodule

// File: tb/tb_psramc_hrr_seq.sv
// Directed bench for psramc_hrr_seq: the bench plays the PSRAM core and checks
// reset pulse timing, read/write sequencing, error handling and reset abort.
module tb_psramc_hrr_seq;

    logic        clk, rst;
    logic        hrr_reset, hrr_read, hrr_write, hrr_wsel;
    logic [15:0] hrr_wdata;
    logic [7:0]  tSYS;
    logic [3:0]  tRP, tRH;
    logic        hrr_rdone;
    logic [63:0] hrr_rdata;
    logic        psram_rst_n, cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_addr;
    logic [15:0] cmd_wdata;
    logic        rsp_valid, rsp_error;
    logic [15:0] rsp_rdata;
    logic        ready, error;

    int total = 0;
    int bad   = 0;
    int rdone_cnt = 0;

    psramc_hrr_seq dut (
        .clk(clk), .rst(rst),
        .hrr_reset(hrr_reset), .hrr_read(hrr_read), .hrr_write(hrr_write),
        .hrr_wsel(hrr_wsel), .hrr_wdata(hrr_wdata),
        .tSYS(tSYS), .tRP(tRP), .tRH(tRH),
        .hrr_rdone(hrr_rdone), .hrr_rdata(hrr_rdata), .psram_rst_n(psram_rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_error(rsp_error),
        .ready(ready), .error(error)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(negedge clk) if (hrr_rdone === 1'b1) rdone_cnt <= rdone_cnt + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic pulse_reset();
        hrr_reset = 1'b1;
        @(negedge clk);
        hrr_reset = 1'b0;
    endtask

    // Count RESET# low cycles, then high cycles until the first command.
    task automatic measure_reset(input string tag, input int lo0, input int exp_lo, input int exp_hi);
        int lo = lo0;
        int hi = 0;
        while (psram_rst_n === 1'b0 && lo < 5000) begin lo++; @(negedge clk); end
        chk({tag, " rst low cycles"}, lo, exp_lo);
        while (cmd_valid !== 1'b1 && psram_rst_n === 1'b1 && hi < 5000) begin hi++; @(negedge clk); end
        chk({tag, " rst high cycles"}, hi, exp_hi);
    endtask

    // Act as the core for one command: check it, stall, accept, respond.
    task automatic serve(input string tag, input logic wr, input logic [31:0] addr,
                         input logic [15:0] wdata, input int stall,
                         input logic [15:0] rdata, input logic err);
        int n = 0;
        while (cmd_valid !== 1'b1 && n < 2000) begin n++; @(negedge clk); end
        chk({tag, " cmd_valid"}, cmd_valid, 1);
        chk({tag, " cmd_write"}, cmd_write, wr);
        chk({tag, " cmd_addr"}, cmd_addr, addr);
        if (wr) chk({tag, " cmd_wdata"}, cmd_wdata, wdata);
        repeat (stall) @(negedge clk);
        if (stall > 0) chk({tag, " held"}, {cmd_valid, cmd_addr}, {1'b1, addr});
        cmd_ready = 1'b1;
        @(negedge clk);
        cmd_ready = 1'b0;
        chk({tag, " valid drop"}, cmd_valid, 0);
        @(negedge clk);
        rsp_valid = 1'b1; rsp_rdata = rdata; rsp_error = err;
        @(negedge clk);
        rsp_valid = 1'b0; rsp_rdata = '0; rsp_error = 1'b0;
    endtask

    initial begin
        int r0;
        int n;
        rst = 1'b1; hrr_reset = 0; hrr_read = 0; hrr_write = 0; hrr_wsel = 0;
        hrr_wdata = '0; tSYS = 8'd10; tRP = 4'd2; tRH = 4'd2;
        cmd_ready = 0; rsp_valid = 0; rsp_rdata = '0; rsp_error = 0;
        repeat (3) @(negedge clk);
        chk("reset psram_rst_n", psram_rst_n, 1);
        chk("reset cmd_valid", cmd_valid, 0);
        chk("reset rdone", hrr_rdone, 0);
        chk("reset rdata", hrr_rdata, 64'h0);
        chk("reset ready", ready, 0);
        chk("reset error", error, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("idle no cmd", cmd_valid, 0);

        // 1) reset pulse timing at 10 ns clock, 2 us / 2 us
        pulse_reset();
        chk("t1 ready in reset", ready, 0);
        measure_reset("t1", 0, 200, 200);

        // 2) auto-read with varying cmd_ready stalls
        r0 = rdone_cnt;
        serve("t2 id0", 0, 32'h0, 16'h0, 0, 16'h0C81, 0);
        serve("t2 id1", 0, 32'h1, 16'h0, 3, 16'h0001, 0);
        serve("t2 cr0", 0, 32'h800, 16'h0, 1, 16'h8F1F, 0);
        serve("t2 cr1", 0, 32'h801, 16'h0, 2, 16'h0002, 0);
        chk("t2 rdata", hrr_rdata, 64'h0002_8F1F_0001_0C81);
        chk("t2 ready", ready, 1);
        @(negedge clk);
        chk("t2 rdone count", rdone_cnt - r0, 1);

        // 3) write CR1
        r0 = rdone_cnt;
        hrr_write = 1; hrr_wsel = 1; hrr_wdata = 16'h00C1;
        @(negedge clk);
        hrr_write = 0; hrr_wsel = 0; hrr_wdata = '0;
        chk("t3 ready busy", ready, 0);
        serve("t3 wr", 1, 32'h801, 16'h00C1, 1, 16'h0, 0);
        chk("t3 rdata", hrr_rdata, 64'h00C1_8F1F_0001_0C81);
        chk("t3 ready", ready, 1);
        @(negedge clk);
        chk("t3 no rdone", rdone_cnt - r0, 0);

        // 4) read and write in the same idle cycle: read wins, write follows
        r0 = rdone_cnt;
        hrr_read = 1; hrr_write = 1; hrr_wsel = 0; hrr_wdata = 16'hABCD;
        @(negedge clk);
        hrr_read = 0; hrr_write = 0; hrr_wdata = '0;
        chk("t4 ready busy", ready, 0);
        serve("t4 id0", 0, 32'h0, 16'h0, 0, 16'h1111, 0);
        serve("t4 id1", 0, 32'h1, 16'h0, 0, 16'h2222, 0);
        serve("t4 cr0", 0, 32'h800, 16'h0, 0, 16'h3333, 0);
        serve("t4 cr1", 0, 32'h801, 16'h0, 0, 16'h4444, 0);
        chk("t4 rdata after read", hrr_rdata, 64'h4444_3333_2222_1111);
        serve("t4 wr", 1, 32'h800, 16'hABCD, 2, 16'h0, 0);
        chk("t4 rdata after write", hrr_rdata, 64'h4444_ABCD_2222_1111);
        n = 0;
        repeat (20) begin @(negedge clk); if (cmd_valid === 1'b1) n++; end
        chk("t4 no extra cmd", n, 0);
        chk("t4 rdone count", rdone_cnt - r0, 1);

        // 5) error on ID1, then a short reset (tRP=1, tRH=0 -> 1 us each) clears it
        r0 = rdone_cnt;
        hrr_read = 1;
        @(negedge clk);
        hrr_read = 0;
        serve("t5 id0", 0, 32'h0, 16'h0, 0, 16'h5555, 0);
        serve("t5 id1", 0, 32'h1, 16'h0, 0, 16'h6666, 1);
        chk("t5 error", error, 1);
        chk("t5 ready", ready, 0);
        chk("t5 rdata kept", hrr_rdata, 64'h4444_ABCD_2222_1111);
        n = 0;
        repeat (10) begin @(negedge clk); if (cmd_valid === 1'b1) n++; end
        chk("t5 idle after error", n, 0);
        chk("t5 no rdone", rdone_cnt - r0, 0);
        tRP = 4'd1; tRH = 4'd0;
        pulse_reset();
        chk("t5 error cleared", error, 0);
        measure_reset("t5", 0, 100, 100);
        serve("t5 id0b", 0, 32'h0, 16'h0, 0, 16'hA000, 0);
        serve("t5 id1b", 0, 32'h1, 16'h0, 0, 16'hA001, 0);
        serve("t5 cr0b", 0, 32'h800, 16'h0, 0, 16'hA002, 0);
        serve("t5 cr1b", 0, 32'h801, 16'h0, 0, 16'hA003, 0);
        chk("t5 rdata", hrr_rdata, 64'hA003_A002_A001_A000);
        chk("t5 ready", ready, 1);

        // 6) reset while waiting on ID1; the stale response must be ignored
        hrr_read = 1;
        @(negedge clk);
        hrr_read = 0;
        serve("t6 id0", 0, 32'h0, 16'h0, 0, 16'hB000, 0);
        n = 0;
        while (cmd_valid !== 1'b1 && n < 2000) begin n++; @(negedge clk); end
        chk("t6 id1 addr", cmd_addr, 32'h1);
        cmd_ready = 1;
        @(negedge clk);
        cmd_ready = 0;
        tSYS = 8'd20; tRP = 4'd1; tRH = 4'd1;
        pulse_reset();
        chk("t6 rst_lo entered", psram_rst_n, 0);
        rsp_valid = 1; rsp_error = 1; rsp_rdata = 16'hDEAD;
        @(negedge clk);
        rsp_valid = 0; rsp_error = 0; rsp_rdata = '0;
        chk("t6 stale rsp ignored", error, 0);
        chk("t6 rdata kept", hrr_rdata, 64'hA003_A002_A001_A000);
        r0 = rdone_cnt;
        measure_reset("t6", 1, 50, 50);
        serve("t6 id0b", 0, 32'h0, 16'h0, 1, 16'hC000, 0);
        serve("t6 id1b", 0, 32'h1, 16'h0, 0, 16'hC001, 0);
        serve("t6 cr0b", 0, 32'h800, 16'h0, 0, 16'hC002, 0);
        serve("t6 cr1b", 0, 32'h801, 16'h0, 0, 16'hC003, 0);
        chk("t6 rdata", hrr_rdata, 64'hC003_C002_C001_C000);
        chk("t6 ready", ready, 1);
        @(negedge clk);
        chk("t6 rdone count", rdone_cnt - r0, 1);
        chk("t6 error", error, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
